countdown_timer: RTL and testbench



---
 rtl/countdown_pkg.sv | 20 ++
 rtl/countdown_timer_digit.sv | 35 +++
 rtl/countdown_timer.sv | 133 +++++++++++++
 tb/tb_countdown_timer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the BCD mm:ss countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    localparam int BCD_MAX       = 9;
    localparam int SEC_TENS_WRAP = 5;

    typedef struct packed {
        logic [3:0] m10;
        logic [3:0] m1;
        logic [2:0] s10;
        logic [3:0] s1;
    } mmss_t;

    function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/countdown_timer_digit.sv
// One BCD down-counting digit: parallel load, decrement with wrap, borrow out.
module bcd_down_digit #(
    parameter int W    = 4,
    parameter int WRAP = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_en_i,
    output logic [W-1:0] digit_o,
    output logic         is_zero_o,
    output logic         borrow_o
);

    logic [W-1:0] digit_q, digit_d;

    assign is_zero_o = (digit_q == '0);
    assign borrow_o  = dec_en_i & is_zero_o;
    assign digit_o   = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load_i)
            digit_d = load_val_i;
        else if (dec_en_i)
            digit_d = is_zero_o ? W'(WRAP) : digit_q - W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) digit_q <= '0;
        else       digit_q <= digit_d;
    end

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with load/start/pause control and a done pulse.
// Optional AUTO_RELOAD_EN: on expiry, reload from the preset and keep running.
module countdown_timer #(
    parameter int MIN_TENS_MAX  = 9,
    parameter int SEC_TENS_WRAP = countdown_pkg::SEC_TENS_WRAP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic [3:0] pre_min_10,
    input  logic [3:0] pre_min_1,
    input  logic [2:0] pre_sec_10,
    input  logic [3:0] pre_sec_1,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_10,
    output logic [3:0] min_1,
    output logic [2:0] sec_10,
    output logic [3:0] sec_1,
    output logic       running,
    output logic       done,
    output logic       expired
);
    import countdown_pkg::*;

    localparam logic [3:0] M10_LIM = 4'(MIN_TENS_MAX);
    localparam logic [3:0] S10_LIM = 4'(SEC_TENS_WRAP);
    localparam logic [3:0] BCD_LIM = 4'(BCD_MAX);

    state_t state_q, state_d;
    logic   done_q, done_d;
    logic   dec_en, reload, dig_load;
    logic   z_m10, z_m1, z_s10, z_s1;
    logic   b_s1, b_s10, b_m1, unused_borrow;
    logic   count_zero, at_one, preset_zero;
    mmss_t  ld_val, dig_val;

    assign ld_val.m10 = clamp_digit(pre_min_10, M10_LIM);
    assign ld_val.m1  = clamp_digit(pre_min_1, BCD_LIM);
    assign ld_val.s10 = 3'(clamp_digit({1'b0, pre_sec_10}, S10_LIM));
    assign ld_val.s1  = clamp_digit(pre_sec_1, BCD_LIM);

`ifdef AUTO_RELOAD_EN
    mmss_t preset_q;

    always_ff @(posedge clk) begin
        if (rst)       preset_q <= '0;
        else if (load) preset_q <= ld_val;
    end

    assign preset_zero = (preset_q == '0);
    assign dig_val     = load ? ld_val : preset_q;
`else
    assign preset_zero = 1'b1;
    assign dig_val     = ld_val;
`endif

    assign dig_load   = load | reload;
    assign count_zero = z_m10 & z_m1 & z_s10 & z_s1;
    assign at_one     = z_m10 & z_m1 & z_s10 & (sec_1 == 4'd1);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        dec_en  = 1'b0;
        reload  = 1'b0;
        if (load) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start && !pause && !count_zero) state_d = RUN;
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick_1hz && !count_zero) begin
                        if (at_one) begin
                            done_d = 1'b1;
                            // Reloading a zero preset would spin forever; expire instead.
                            if (preset_zero) begin
                                dec_en  = 1'b1;
                                state_d = EXPIRED;
                            end else begin
                                reload = 1'b1;
                            end
                        end else begin
                            dec_en = 1'b1;
                        end
                    end
                end
                PAUSED:  if (start && !pause) state_d = RUN;
                EXPIRED: state_d = EXPIRED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign running = (state_q == RUN);
    assign expired = (state_q == EXPIRED);
    assign done    = done_q;

    bcd_down_digit #(.W(4), .WRAP(BCD_MAX)) u_sec_1 (
        .clk_i(clk), .rst_i(rst), .load_i(dig_load), .load_val_i(dig_val.s1),
        .dec_en_i(dec_en), .digit_o(sec_1), .is_zero_o(z_s1), .borrow_o(b_s1)
    );

    bcd_down_digit #(.W(3), .WRAP(SEC_TENS_WRAP)) u_sec_10 (
        .clk_i(clk), .rst_i(rst), .load_i(dig_load), .load_val_i(dig_val.s10),
        .dec_en_i(b_s1), .digit_o(sec_10), .is_zero_o(z_s10), .borrow_o(b_s10)
    );

    bcd_down_digit #(.W(4), .WRAP(BCD_MAX)) u_min_1 (
        .clk_i(clk), .rst_i(rst), .load_i(dig_load), .load_val_i(dig_val.m1),
        .dec_en_i(b_s10), .digit_o(min_1), .is_zero_o(z_m1), .borrow_o(b_m1)
    );

    // Never borrows: the count is not decremented below 00:00.
    bcd_down_digit #(.W(4), .WRAP(MIN_TENS_MAX)) u_min_10 (
        .clk_i(clk), .rst_i(rst), .load_i(dig_load), .load_val_i(dig_val.m10),
        .dec_en_i(b_m1), .digit_o(min_10), .is_zero_o(z_m10), .borrow_o(unused_borrow)
    );

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: seconds-based reference model checked every cycle,
// plus literal expectations after each scenario.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [3:0] pre_min_10 = '0, pre_min_1 = '0, pre_sec_1 = '0;
    logic [2:0] pre_sec_10 = '0;
    logic [3:0] min_10, min_1, sec_1;
    logic [2:0] sec_10;
    logic       running, done, expired;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    countdown_timer dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .load(load),
        .pre_min_10(pre_min_10), .pre_min_1(pre_min_1),
        .pre_sec_10(pre_sec_10), .pre_sec_1(pre_sec_1),
        .start(start), .pause(pause),
        .min_10(min_10), .min_1(min_1), .sec_10(sec_10), .sec_1(sec_1),
        .running(running), .done(done), .expired(expired)
    );

    always #5 clk = ~clk;

    logic [15:0] dig;
    assign dig = {min_10, min_1, 1'b0, sec_10, sec_1};

    // Reference model: total seconds remaining plus a mode number
    // (0 idle, 1 run, 2 paused, 3 expired).
    int m_secs = 0, m_preset = 0, m_mode = 0;
    bit m_done = 1'b0;

    function automatic int lim(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk) begin
        chk_en <= 1'b1;
        m_done = 1'b0;
        if (rst) begin
            m_secs = 0; m_preset = 0; m_mode = 0;
        end else if (load) begin
            m_secs = lim(int'(pre_min_10), 9) * 600 + lim(int'(pre_min_1), 9) * 60
                   + lim(int'(pre_sec_10), 5) * 10 + lim(int'(pre_sec_1), 9);
            m_preset = m_secs;
            m_mode = 0;
        end else if (m_mode == 1) begin
            if (pause) m_mode = 2;
            else if (tick_1hz && m_secs > 0) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_done = 1'b1;
`ifdef AUTO_RELOAD_EN
                    if (m_preset > 0) m_secs = m_preset;
                    else m_mode = 3;
`else
                    m_mode = 3;
`endif
                end
            end
        end else if (m_mode == 0) begin
            if (start && !pause && m_secs > 0) m_mode = 1;
        end else if (m_mode == 2) begin
            if (start && !pause) m_mode = 1;
        end
    end

    function automatic logic [18:0] model_out();
        int mm, ss;
        logic [15:0] d;
        mm = m_secs / 60;
        ss = m_secs % 60;
        d = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        return {d, m_mode == 1, m_done, m_mode == 3};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({dig, running, done, expired} !== model_out()) begin
                errors++;
                $display("FAIL cycle t=%0t got mmss=%h run=%b done=%b exp=%b need %h", $time,
                         dig, running, done, expired, model_out());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h need %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic l, input logic s, input logic p, input logic t);
        @(negedge clk);
        load = l; start = s; pause = p; tick_1hz = t;
        @(negedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0; tick_1hz = 1'b0;
    endtask

    task automatic preset(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c,
                          input logic [3:0] d);
        pre_min_10 = a; pre_min_1 = b; pre_sec_10 = c; pre_sec_1 = d;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_digits", 32'(dig), 32'h0000);
        chk("reset_flags", {29'd0, running, done, expired}, 32'd0);

        // 01:00 -> 00:59 -> 00:00
        preset(4'd0, 4'd1, 3'd0, 4'd0);
        chk("load_0100", 32'(dig), 32'h0100);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_running", 32'(running), 32'd1);
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        chk("first_tick_0059", 32'(dig), 32'h0059);
        for (int i = 0; i < 58; i++) apply(1'b0, 1'b0, 1'b0, 1'b1);
        chk("at_0001", 32'(dig), 32'h0001);
        apply(1'b0, 1'b0, 1'b0, 1'b1);
`ifndef AUTO_RELOAD_EN
        chk("expire_digits", 32'(dig), 32'h0000);
        chk("expire_flags", {29'd0, running, done, expired}, 32'b011);
        @(negedge clk);
        chk("done_one_cycle", {29'd0, running, done, expired}, 32'b001);
        apply(1'b0, 1'b1, 1'b0, 1'b1);
        chk("expired_holds", {16'd0, dig}, 32'h0000);
`endif

        // Full borrow chain in one tick
        preset(4'd1, 4'd0, 3'd0, 4'd0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        chk("borrow_1000_0959", 32'(dig), 32'h0959);

        // Clamping
        preset(4'd12, 4'd3, 3'd7, 4'd11);
        chk("clamp_load", 32'(dig), 32'h9359);
        chk("load_to_idle", 32'(running), 32'd0);

        // Pause beats tick, start+pause stays paused, resume to expiry
        preset(4'd0, 4'd0, 3'd0, 4'd5);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        chk("pause_vs_tick", {15'd0, running, dig}, 32'h0005);
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        chk("start_pause_together", 32'(running), 32'd0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        chk("resume", 32'(running), 32'd1);
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 1'b0, 1'b1);
        chk("resume_0001", 32'(dig), 32'h0001);
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        chk("resume_done", 32'(done), 32'd1);

        // Start at 00:00 ignored
        preset(4'd0, 4'd0, 3'd0, 4'd0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_zero_ignored", {29'd0, running, done, expired}, 32'd0);

        // Load with a simultaneous tick drops the tick
        preset(4'd0, 4'd0, 3'd0, 4'd9);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        pre_sec_1 = 4'd7;
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        chk("load_beats_tick", {15'd0, running, dig}, 32'h0007);

        // Reset mid-run at 00:01
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) apply(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre_reset_0001", 32'(dig), 32'h0001);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("reset_midrun", {13'd0, dig, running, done, expired}, 32'd0);
        @(negedge clk);
        chk("reset_no_done", 32'(done), 32'd0);

`ifdef AUTO_RELOAD_EN
        preset(4'd0, 4'd0, 3'd0, 4'd2);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 1'b0, 1'b1);
        chk("auto_reload_digits", {15'd0, running, dig}, 32'h10002);
        chk("auto_reload_not_expired", 32'(expired), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
